mips_multicycle: RTL and testbench

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

---
 rtl/mips_multicycle.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_mips_multicycle.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core: one shared ALU, one unified memory port with
// a ready handshake, and a two-process FSM. Memory-port outputs are decoded
// only from registered state, so they carry no combinational input paths.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] adr,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        memready,
    output logic [31:0] pc,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_IMMEXE = 4'd8,
        S_IMMWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // True for the R-type function codes this core implements.
    function automatic logic funct_supported(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_supported = 1'b1;
            default:                               funct_supported = 1'b0;
        endcase
    endfunction

    // Maps an R-type function code onto the shared ALU operation.
    function automatic alu_op_t funct_to_op(input logic [5:0] fn);
        case (fn)
            FN_SUB:  funct_to_op = ALU_SUB;
            FN_AND:  funct_to_op = ALU_AND;
            FN_OR:   funct_to_op = ALU_OR;
            FN_SLT:  funct_to_op = ALU_SLT;
            default: funct_to_op = ALU_ADD;
        endcase
    endfunction

    state_t      state_r;
    state_t      state_n_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] aluout_r;
    logic [31:0] mdr_r;
    logic [31:0] regs_r [32];

    logic [5:0]  op_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [5:0]  funct_s;
    logic [31:0] sext_s;
    logic [31:0] zext_s;
    state_t      illegal_next_s;

    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    alu_op_t     alu_op_s;
    logic [31:0] alu_y_s;

    logic        rf_we_s;
    logic [4:0]  rf_wa_s;
    logic [31:0] rf_wd_s;
    logic        take_s;

    assign op_s    = instr_r[31:26];
    assign rs_s    = instr_r[25:21];
    assign rt_s    = instr_r[20:16];
    assign rd_s    = instr_r[15:11];
    assign funct_s = instr_r[5:0];
    assign sext_s  = {{16{instr_r[15]}}, instr_r[15:0]};
    assign zext_s  = {16'h0000, instr_r[15:0]};
    assign illegal_next_s = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
    assign take_s  = (op_s == OP_BEQ) ? (a_r == b_r) : (a_r != b_r);

    // Shared ALU operand selection: each state borrows the ALU for one job.
    always_comb begin
        alu_a_s  = pc_r;
        alu_b_s  = 32'd4;
        alu_op_s = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                alu_a_s = pc_r;
                alu_b_s = 32'd4;
            end
            S_DECODE: begin
                alu_a_s = pc_r;
                alu_b_s = {sext_s[29:0], 2'b00};
            end
            S_MEMADR: begin
                alu_a_s = a_r;
                alu_b_s = sext_s;
            end
            S_RTEXE: begin
                alu_a_s  = a_r;
                alu_b_s  = b_r;
                alu_op_s = funct_to_op(funct_s);
            end
            S_IMMEXE: begin
                alu_a_s = a_r;
                if (op_s == OP_ORI) begin
                    alu_b_s  = zext_s;
                    alu_op_s = ALU_OR;
                end else begin
                    alu_b_s  = sext_s;
                    alu_op_s = ALU_ADD;
                end
            end
            default: begin
                alu_a_s  = pc_r;
                alu_b_s  = 32'd4;
                alu_op_s = ALU_ADD;
            end
        endcase
    end

    // ALU function; arithmetic wraps modulo 2^32, slt compares signed.
    always_comb begin
        alu_y_s = 32'h0000_0000;
        case (alu_op_s)
            ALU_ADD: alu_y_s = alu_a_s + alu_b_s;
            ALU_SUB: alu_y_s = alu_a_s - alu_b_s;
            ALU_AND: alu_y_s = alu_a_s & alu_b_s;
            ALU_OR:  alu_y_s = alu_a_s | alu_b_s;
            ALU_SLT: alu_y_s = ($signed(alu_a_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
            default: alu_y_s = 32'h0000_0000;
        endcase
    end

    // Next-state logic for the instruction sequencer.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            S_FETCH:  state_n_s = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_s)
                    OP_LW, OP_SW:   state_n_s = S_MEMADR;
                    OP_RTYPE:       state_n_s = funct_supported(funct_s) ? S_RTEXE : illegal_next_s;
                    OP_ADDI, OP_ORI: state_n_s = S_IMMEXE;
                    OP_BEQ, OP_BNE: state_n_s = S_BRANCH;
                    OP_J:           state_n_s = S_JUMP;
                    default:        state_n_s = illegal_next_s;
                endcase
            end
            S_MEMADR: state_n_s = (op_s == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_n_s = memready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_n_s = S_FETCH;
            S_MEMWR:  state_n_s = memready ? S_FETCH : S_MEMWR;
            S_RTEXE:  state_n_s = S_RTWB;
            S_RTWB:   state_n_s = S_FETCH;
            S_IMMEXE: state_n_s = S_IMMWB;
            S_IMMWB:  state_n_s = S_FETCH;
            S_BRANCH: state_n_s = S_FETCH;
            S_JUMP:   state_n_s = S_FETCH;
            S_HALT:   state_n_s = S_HALT;
            default:  state_n_s = S_FETCH;
        endcase
    end

    // Register-file write port; writes to $0 are dropped here.
    always_comb begin
        rf_we_s = 1'b0;
        rf_wa_s = 5'd0;
        rf_wd_s = 32'h0000_0000;
        case (state_r)
            S_MEMWB: begin
                rf_we_s = 1'b1;
                rf_wa_s = rt_s;
                rf_wd_s = mdr_r;
            end
            S_RTWB: begin
                rf_we_s = 1'b1;
                rf_wa_s = rd_s;
                rf_wd_s = aluout_r;
            end
            S_IMMWB: begin
                rf_we_s = 1'b1;
                rf_wa_s = rt_s;
                rf_wd_s = aluout_r;
            end
            default: begin
                rf_we_s = 1'b0;
                rf_wa_s = 5'd0;
                rf_wd_s = 32'h0000_0000;
            end
        endcase
        if (rf_wa_s == 5'd0) begin
            rf_we_s = 1'b0;
        end else begin
            rf_we_s = rf_we_s;
        end
    end

    // Memory-port outputs decoded from state; requests only in access states.
    always_comb begin
        adr       = pc_r;
        memread   = 1'b0;
        memwrite  = 1'b0;
        writedata = b_r;
        case (state_r)
            S_FETCH: begin
                adr     = pc_r;
                memread = 1'b1;
            end
            S_MEMRD: begin
                adr     = aluout_r;
                memread = 1'b1;
            end
            S_MEMWR: begin
                adr      = aluout_r;
                memwrite = 1'b1;
            end
            default: begin
                adr      = pc_r;
                memread  = 1'b0;
                memwrite = 1'b0;
            end
        endcase
    end

    assign pc     = pc_r;
    assign halted = (state_r == S_HALT);

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Datapath registers and register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= RESET_PC;
            instr_r  <= 32'h0000_0000;
            a_r      <= 32'h0000_0000;
            b_r      <= 32'h0000_0000;
            aluout_r <= 32'h0000_0000;
            mdr_r    <= 32'h0000_0000;
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (memready) begin
                        instr_r <= readdata;
                        pc_r    <= alu_y_s;
                    end
                end
                S_DECODE: begin
                    a_r      <= (rs_s == 5'd0) ? 32'h0000_0000 : regs_r[rs_s];
                    b_r      <= (rt_s == 5'd0) ? 32'h0000_0000 : regs_r[rt_s];
                    aluout_r <= alu_y_s;
                end
                S_MEMADR, S_RTEXE, S_IMMEXE: aluout_r <= alu_y_s;
                S_MEMRD: begin
                    if (memready) begin
                        mdr_r <= readdata;
                    end
                end
                S_BRANCH: begin
                    if (take_s) begin
                        pc_r <= aluout_r;
                    end
                end
                S_JUMP:  pc_r <= {pc_r[31:28], instr_r[25:0], 2'b00};
                default: ;
            endcase
            if (rf_we_s) begin
                regs_r[rf_wa_s] <= rf_wd_s;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: small programs in a bench-owned
// memory, outputs sampled on the falling edge against hand-computed values.
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] adr;
    logic        memread;
    logic        memwrite;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        memready;
    logic [31:0] pc;
    logic        halted;

    logic [31:0] prog [256];
    logic [31:0] mem  [256];
    int          wait_cnt;
    int          wr_delay;
    int          checks;
    int          errors;

    mips_multicycle #(
        .RESET_PC(32'h0000_0000),
        .HALT_ON_ILLEGAL(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .adr(adr),
        .memread(memread),
        .memwrite(memwrite),
        .writedata(writedata),
        .readdata(readdata),
        .memready(memready),
        .pc(pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    assign readdata = mem[adr[9:2]];
    assign memready = memread ? 1'b1 : (memwrite ? (wait_cnt >= wr_delay) : 1'b0);

    // Memory model: reloads the program while reset is high, counts wait cycles.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
            wait_cnt <= 0;
        end else begin
            if ((memread || memwrite) && !memready) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (memwrite && memready) mem[adr[9:2]] <= writedata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0000_0000;
        for (int i = 32'h80; i < 32'h90; i++) prog[i] = 32'hDEAD_BEEF;
    endtask

    task automatic finish_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wr_delay = 0;

        // ---------------- Phase A: main program ----------------
        clear_prog();
        prog[0]  = 32'h2001_0005; // addi $1,$0,5
        prog[1]  = 32'h2002_0007; // addi $2,$0,7
        prog[2]  = 32'h0022_1820; // add  $3,$1,$2
        prog[3]  = 32'hAC03_0008; // sw   $3,8($0)
        prog[4]  = 32'h8C04_0008; // lw   $4,8($0)
        prog[5]  = 32'hAC04_0200; // sw   $4,0x200
        prog[6]  = 32'h0041_2822; // sub  $5,$2,$1
        prog[7]  = 32'hAC05_0204; // sw   $5,0x204
        prog[8]  = 32'h0800_0040; // j    0x40 -> 0x100
        prog[64] = 32'h0022_302A; // slt  $6,$1,$2
        prog[65] = 32'hAC06_0208; // sw   $6,0x208
        prog[66] = 32'h2000_0009; // addi $0,$0,9
        prog[67] = 32'hAC00_020C; // sw   $0,0x20C
        prog[68] = 32'h3407_FFFF; // ori  $7,$0,0xFFFF
        prog[69] = 32'hAC07_0210; // sw   $7,0x210
        prog[70] = 32'h2008_FFFF; // addi $8,$0,-1
        prog[71] = 32'h00E8_4824; // and  $9,$7,$8
        prog[72] = 32'hAC09_0214; // sw   $9,0x214
        prog[73] = 32'h0101_502A; // slt  $10,$8,$1 (signed)
        prog[74] = 32'hAC0A_0218; // sw   $10,0x218
        prog[75] = 32'h0022_5825; // or   $11,$1,$2
        prog[76] = 32'h0108_6020; // add  $12,$8,$8 (wraps)
        prog[77] = 32'hAC0B_021C; // sw   $11,0x21C
        prog[78] = 32'hAC0C_0220; // sw   $12,0x220
        prog[79] = 32'h1421_FFFF; // bne  $1,$1,-1 (not taken)
        prog[80] = 32'hFC00_0000; // illegal opcode 0x3F

        #1 reset = 1'b1;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
        chk("rst_memread", {31'd0, memread}, 32'd1);
        finish_reset();

        repeat (12) tick();
        chk("add_pc", pc, 32'h0000_000C);
        chk("add_adr", adr, 32'h0000_000C);

        wr_delay = 3;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            chk("sw_memwrite", {31'd0, memwrite}, 32'd1);
            chk("sw_memread", {31'd0, memread}, 32'd0);
            chk("sw_adr", adr, 32'h0000_0008);
            chk("sw_wdata", writedata, 32'd12);
            tick();
        end
        chk("sw_done_memwrite", {31'd0, memwrite}, 32'd0);
        chk("sw_done_pc", pc, 32'h0000_0010);
        chk("sw_done_fetch", {31'd0, memread}, 32'd1);
        chk("sw_mem", mem[2], 32'd12);
        wr_delay = 0;

        repeat (4) tick();
        chk("lw_wb_noreq", {31'd0, memread}, 32'd0);
        tick();
        chk("lw_next_adr", adr, 32'h0000_0014);
        chk("lw_next_fetch", {31'd0, memread}, 32'd1);

        for (int i = 0; i < 400 && !halted; i++) tick();
        chk("halt_reached", {31'd0, halted}, 32'd1);
        repeat (5) tick();
        chk("halt_pc", pc, 32'h0000_0144);
        chk("halt_memread", {31'd0, memread}, 32'd0);
        chk("halt_memwrite", {31'd0, memwrite}, 32'd0);
        chk("lw_val", mem[32'h80], 32'd12);
        chk("sub_val", mem[32'h81], 32'd2);
        chk("slt_val", mem[32'h82], 32'd1);
        chk("r0_val", mem[32'h83], 32'd0);
        chk("ori_val", mem[32'h84], 32'h0000_FFFF);
        chk("and_val", mem[32'h85], 32'h0000_FFFF);
        chk("slt_signed", mem[32'h86], 32'd1);
        chk("or_val", mem[32'h87], 32'd7);
        chk("add_wrap", mem[32'h88], 32'hFFFF_FFFE);

        // ---------------- Phase B: beq taken loop ----------------
        clear_prog();
        prog[0] = 32'h2001_0005; // addi $1,$0,5
        prog[1] = 32'h2002_0001;
        prog[2] = 32'h2002_0001;
        prog[3] = 32'h2002_0001;
        prog[4] = 32'h1021_FFFF; // beq $1,$1,-1
        reset = 1'b1;
        #1;
        chk("rst_clears_halt", {31'd0, halted}, 32'd0);
        finish_reset();
        repeat (16) tick();
        chk("beq_start_pc", pc, 32'h0000_0010);
        tick();
        chk("beq_incr_pc", pc, 32'h0000_0014);
        repeat (2) tick();
        chk("beq_taken_pc", pc, 32'h0000_0010);
        repeat (3) tick();
        chk("beq_loop_pc", pc, 32'h0000_0010);

        // ---------------- Phase C: bne not taken ----------------
        prog[4] = 32'h1421_FFFF; // bne $1,$1,-1
        reset = 1'b1;
        finish_reset();
        repeat (19) tick();
        chk("bne_pc", pc, 32'h0000_0014);
        repeat (2) tick();
        chk("funct0_halt", {31'd0, halted}, 32'd1);

        // ---------------- Phase D: async reset mid-MEMWR ----------------
        clear_prog();
        prog[0] = 32'hAC00_0200; // sw $0,0x200
        wr_delay = 10;
        reset = 1'b1;
        finish_reset();
        repeat (3) tick();
        chk("memwr_active", {31'd0, memwrite}, 32'd1);
        chk("memwr_adr", adr, 32'h0000_0200);
        #1 reset = 1'b1;
        #1;
        chk("async_memwrite", {31'd0, memwrite}, 32'd0);
        chk("async_pc", pc, 32'h0);
        chk("async_adr", adr, 32'h0);
        finish_reset();
        chk("post_rst_fetch", {31'd0, memread}, 32'd1);
        chk("post_rst_adr", adr, 32'h0);
        wr_delay = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
